// File: rtl/nand_ug_sequencer_if.sv
// nand_ug_sequencer_if: stimulus/return bundle between the sequencer and the ug block
//   a_o, b_o           : gate inputs driven by the sequencer
//   and_i, or_i, not_i : gate outputs returned from ug
//   master : sequencer side; slave : ug side
interface nand_ug_sequencer_if;
    logic a_o;
    logic b_o;
    logic and_i;
    logic or_i;
    logic not_i;
    modport master (output a_o, b_o, input and_i, or_i, not_i);
    modport slave  (input a_o, b_o, output and_i, or_i, not_i);
endinterface

// File: rtl/nand_ug_sequencer.sv
// nand_ug_sequencer: walks ug through the 2-input truth table and scores its AND/OR/NOT outputs
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, abort    : begin a run (IDLE/DONE only); abort to IDLE from any state
//   ug              : master side of the ug stimulus/return bundle
//   busy, done, pass: run in progress; results valid; results valid with no errors
//   err_count       : total mismatching output bits
//   fail_vec        : per-vector mismatch flags
//   cap_o           : captured {and, or, not} per vector, vector i in bits 3i+2:3i
module nand_ug_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    nand_ug_sequencer_if.master     ug,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [3:0]              err_count,
    output logic [3:0]              fail_vec,
    output logic [11:0]             cap_o
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES);
    state_t      state, state_n;
    logic [1:0]  idx, idx_n;
    logic [7:0]  cnt, cnt_n;
    logic [3:0]  err_n, fail_n;
    logic [11:0] cap_n;
    logic [2:0]  got, ideal, mis;
    logic [1:0]  nmis;
    // the vector index doubles as the stimulus register, so a/b stay glitch-free
    assign ug.a_o  = idx[1];
    assign ug.b_o  = idx[0];
    assign busy    = (state == SETTLE) || (state == SAMPLE);
    assign done    = (state == DONE);
    assign pass    = done && (err_count == 4'd0);
    assign got     = {ug.and_i, ug.or_i, ug.not_i};
    assign ideal   = {idx[1] & idx[0], idx[1] | idx[0], ~idx[1]};
    assign mis     = got ^ ideal;
    assign nmis    = 2'(mis[0]) + 2'(mis[1]) + 2'(mis[2]);
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        err_n   = err_count;
        fail_n  = fail_vec;
        cap_n   = cap_o;
        if (abort) begin
            state_n = IDLE;
            idx_n   = 2'd0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state_n = SETTLE;
                    idx_n   = 2'd0;
                    cnt_n   = RELOAD;
                    err_n   = 4'd0;
                    fail_n  = 4'd0;
                    cap_n   = 12'd0;
                end
                SETTLE: begin
                    cnt_n   = cnt - 8'd1;
                    state_n = (cnt == 8'd1) ? SAMPLE : SETTLE;
                end
                SAMPLE: begin
                    cap_n[3*idx +: 3] = got;
                    err_n             = err_count + 4'(nmis);
                    fail_n[idx]       = |mis;
                    state_n           = (idx == 2'd3) ? DONE : SETTLE;
                    idx_n             = (idx == 2'd3) ? idx : idx + 2'd1;
                    cnt_n             = (idx == 2'd3) ? cnt : RELOAD;
                end
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 2'd0;
            cnt       <= 8'd0;
            err_count <= 4'd0;
            fail_vec  <= 4'd0;
            cap_o     <= 12'd0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            err_count <= err_n;
            fail_vec  <= fail_n;
            cap_o     <= cap_n;
        end
    end
endmodule

// File: doc/nand_ug_sequencer.md
# nand_ug_sequencer

Self-checking stimulus-and-capture sequencer for the NAND-derived universal-gate block (`ug`). It sits directly upstream of `ug`, driving its `a`/`b` inputs through the full 2-input truth table. It also consumes `ug`'s `nand_and`, `nand_or` and `nand_not` outputs on the return path. Each output is compared against the ideal AND/OR/NOT value, and the block reports pass/fail, an error count, per-vector fail flags and the raw captured outputs, so `ug` can be checked in silicon or in a synthesizable bench.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling. Legal range 1..255; counter is 8 bits.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a run; honoured only in IDLE or DONE.
- `abort`, input, 1: synchronous abort; returns to IDLE from any state.
- `a_o`, output, 1: drives `ug.a`.
- `b_o`, output, 1: drives `ug.b`.
- `and_i`, input, 1: from `ug.nand_and`.
- `or_i`, input, 1: from `ug.nand_or`.
- `not_i`, input, 1: from `ug.nand_not`.
- `busy`, output, 1: high in SETTLE and SAMPLE.
- `done`, output, 1: level, high in DONE.
- `pass`, output, 1: high only in DONE with `err_count == 0`.
- `err_count`, output, 4: number of mismatching output bits, 0..12.
- `fail_vec`, output, 4: bit i is set if any output mismatched on vector i.
- `cap_o`, output, 12: `cap_o[3i+2:3i]` = captured {and_i, or_i, not_i} for vector i.

## Operation
- **Vectors:** index `idx` 0..3; `a_o = idx[1]`, `b_o = idx[0]`. Order is 00, 01, 10, 11.
- **Expected values:** and = a&b, or = a|b, not = ~a.
- **FSM states:** IDLE, SETTLE, SAMPLE, DONE.
- **IDLE/DONE + start:**
  - Clear `err_count`, `fail_vec`, `cap_o`.
  - Set `idx = 0` and drive vector 0.
  - Load `cnt = SETTLE_CYCLES`; go to SETTLE.
- **SETTLE:** decrement `cnt` each cycle; when `cnt == 1`, go to SAMPLE.
- **SAMPLE (one cycle):**
  - Register {and_i, or_i, not_i} into `cap_o` slot `idx`.
  - Add the number of mismatching bits (0..3) to `err_count`.
  - Set `fail_vec[idx]` if that number is nonzero.
  - If `idx == 3`: go to DONE; `a_o`/`b_o` hold vector 3.
  - Otherwise: increment `idx`, drive the next vector, reload `cnt`, go to SETTLE.
- **DONE:** results hold stable until the next `start` or reset.
- **Start while busy:** ignored, with no effect on the run.
- **abort:** takes priority over `start` in the same cycle.
  - Go to IDLE and drive `a_o = b_o = 0`.
  - `done` and `pass` drop to 0; `err_count`, `fail_vec` and `cap_o` keep their partial values.
- **Start in DONE:** restarts a run; `done` falls on the same edge that enters SETTLE.
- **Arithmetic:** `err_count` is 4-bit unsigned and cannot overflow (max 12).

## Timing
- **Reset values:** state IDLE, `a_o = b_o = 0`, `busy = done = pass = 0`, `err_count = 0`, `fail_vec = 0`, `cap_o = 0`, `idx = 0`, `cnt = 0`.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs to outputs.
- **Start edge:** `start` is sampled at edge k. Vector 0 appears and `busy` rises after edge k.
- **Per-vector timing:**
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - Inputs are sampled at edge k + (i+1)(SETTLE_CYCLES+1) for vector i.
  - Inputs have then been stable for SETTLE_CYCLES+1 cycles, which covers the combinational delay of `ug`.
- **Run end:** `done` and `pass` rise and `busy` falls after edge k + 4(SETTLE_CYCLES+1); that is edge k+12 at the default setting.
- **Reset mid-run:** asynchronous return to the reset values listed above. No `done` pulse is produced.

## Test plan
- **Good `ug`, SETTLE_CYCLES = 2:**
  - Pulse `start` one cycle.
  - `done` rises 12 cycles after the start edge.
  - `pass = 1`, `err_count = 0`, `fail_vec = 4'b0000`, `cap_o = 12'hC99`.
  - Vector sequence (a,b) observed as 00, 01, 10, 11, each held 3 cycles.
- **`and_i` stuck at 0:** `err_count = 1`, `fail_vec = 4'b1000`, `pass = 0`, `cap_o = 12'h499`.
- **`or_i` stuck at 0:** `err_count = 3`, `fail_vec = 4'b1110`; `not_i` inverted: `err_count = 4`, `fail_vec = 4'b1111`; all three inverted: `err_count = 12`.
- **Start while busy:**
  - Re-pulse `start` at cycles 3 and 7 of a run.
  - Required: no restart; `done` still at cycle 12 with results identical to the first scenario.
- **Abort and restart:**
  - Assert `abort` at cycle 5 → IDLE, `a_o = b_o = 0`, `done = 0`.
  - Assert `start` and `abort` together → stays IDLE.
  - A subsequent `start` gives a clean full run with `pass = 1`.
- **Reset and SETTLE_CYCLES = 1:**
  - Assert `rst_n = 0` mid-SETTLE of vector 2 → all outputs reach reset values without waiting for a clock edge.
  - After release, a run with SETTLE_CYCLES = 1 gives `done` 8 cycles after start, with `pass = 1`.
